hpi_responder: RTL and testbench
================================

Name: hpi_responder

Overview:
- Synthesizable responder for the 16-bit OTG host-port-interface (HPI) bus.
- The Nios-side PIO exports (address, cs, r, w, data in/out) act as initiator; this block answers them the way the USB controller's HPI slave does.
- Provides a word RAM reached through an auto-incrementing address pointer, a bidirectional mailbox, and a status register.
- Used as an on-chip stand-in for the USB controller so the firmware HPI driver can be exercised in simulation and on the board.

Parameters:
- DEPTH_WORDS, 256, number of 16-bit RAM words; must be a power of 2.
- RESET_ADDR, 16'h0000, reset value of the HPI address pointer (byte address).

Ports:
- Clk  input  1  system clock; all HPI strobes are synchronous to it.
- Reset  input  1  asynchronous, active-high reset.
- hpi_addr  input  2  register select: 00 DATA, 01 MAILBOX, 10 ADDRESS, 11 STATUS.
- hpi_cs_n  input  1  chip select, active low.
- hpi_r_n  input  1  read strobe, active low.
- hpi_w_n  input  1  write strobe, active low.
- hpi_data_in  input  16  write data from initiator.
- hpi_data_out  output  16  read data to initiator.
- dev_mbx_wr  input  1  device side writes the outbound mailbox (one-cycle pulse).
- dev_mbx_wdata  input  16  outbound mailbox value.
- dev_mbx_ack  input  1  device side consumes the inbound mailbox (pulse).
- dev_mbx_rdata  output  16  last inbound mailbox value from host.
- dev_mbx_irq  output  1  equals the MBX_IN flag.
- protocol_err  output  1  sticky error flag.

Behaviour:
- Reset values:
  - address pointer = RESET_ADDR.
  - hpi_data_out, dev_mbx_rdata, outbound mailbox = 0.
  - MBX_IN, MBX_OUT, protocol_err = 0.
  - RAM contents are not reset.
- Strobe detection:
  - Register previous r_n and w_n.
  - A write fires on the first cycle with cs_n=0, w_n=0 and prev w_n=1.
  - A read starts on the first cycle with cs_n=0, r_n=0 and prev r_n=1.
  - A read completes on the cycle prev r_n=0 and r_n=1. The address latched at read start is used, not the live hpi_addr.
  - Strobes held low for more than one cycle do not re-fire.
- Writes:
  - DATA: RAM[ptr[log2(DEPTH_WORDS):1]] <= data_in; then ptr += 2.
  - MAILBOX: dev_mbx_rdata <= data_in; MBX_IN <= 1.
  - ADDRESS: ptr <= data_in; bit 0 is forced to 0.
  - STATUS: ignored.
- Read latency: hpi_data_out is registered and valid 1 cycle after read start. It holds its value until the next read start.
  - DATA: RAM word at ptr.
  - MAILBOX: outbound mailbox value.
  - ADDRESS: ptr.
  - STATUS: {14'b0, MBX_IN, MBX_OUT}.
- Read side effects (applied at read completion):
  - DATA: ptr += 2.
  - MAILBOX: MBX_OUT <= 0.
- Address arithmetic:
  - ptr is 16 bits; 16'hFFFE + 2 wraps to 16'h0000.
  - RAM index = ptr bits [log2(DEPTH_WORDS):1]; addresses beyond RAM alias modulo DEPTH_WORDS.
- Device mailbox:
  - dev_mbx_wr loads the outbound mailbox and sets MBX_OUT, overwriting any unread value.
  - dev_mbx_ack clears MBX_IN.
- Simultaneous events:
  - Host mailbox write and dev_mbx_ack in the same cycle: MBX_IN ends at 1.
  - Host mailbox-read completion and dev_mbx_wr in the same cycle: MBX_OUT ends at 1; the new value is stored.
- Protocol errors: r_n=0 and w_n=0 with cs_n=0 in the same cycle → no access fires, protocol_err <= 1 (sticky until Reset). Strobes with cs_n=1 are ignored entirely.
- Reset mid-access: all state returns to reset values immediately; a strobe still held low after release does not fire, because prev strobe registers reset to 1 only when strobes are high.

Test Plan:
- Reset, then read STATUS and ADDRESS → 16'h0000 and RESET_ADDR; protocol_err=0.
- Write ADDRESS=16'h0010, write DATA 16'hBEEF and 16'hCAFE, write ADDRESS=16'h0010, read DATA twice → BEEF then CAFE; read ADDRESS → 16'h0014.
- Write ADDRESS=16'hFFFE, write DATA 16'h1234, read ADDRESS → 16'h0000. Write ADDRESS=16'h01FE (DEPTH 256), read DATA → 1234 via aliasing.
- Host writes MAILBOX 16'h00A5 → dev_mbx_irq=1, dev_mbx_rdata=00A5, STATUS=0002. Pulse dev_mbx_ack → STATUS=0000.
- Pulse dev_mbx_wr with 16'h5A5A → STATUS=0001. Host reads MAILBOX → 5A5A; STATUS reads 0000 after completion.
- Assert r_n=0 and w_n=0 together with cs_n=0 → no RAM, pointer, or mailbox change; protocol_err=1 until Reset. Hold w_n low 5 cycles on DATA → exactly one write, ptr +2.

Source files
------------

// File: rtl/hpi_responder.sv
// HPI bus responder: word RAM behind an auto-incrementing byte pointer,
// a two-way mailbox and a status register, answering the host-side strobes
// the way the USB controller's HPI slave does.
module hpi_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [15:0] RESET_ADDR  = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  hpi_addr,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    input  logic        dev_mbx_wr,
    input  logic [15:0] dev_mbx_wdata,
    input  logic        dev_mbx_ack,
    output logic [15:0] dev_mbx_rdata,
    output logic        dev_mbx_irq,
    output logic        protocol_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        SEL_DATA = 2'b00,
        SEL_MBX  = 2'b01,
        SEL_ADDR = 2'b10,
        SEL_STAT = 2'b11
    } sel_t;

    logic          prev_r_n, prev_w_n;
    logic          rd_active;
    sel_t          rd_sel;
    logic [15:0]   ptr;
    logic [15:0]   mbx_out_val;
    logic          mbx_in, mbx_out;
    logic [15:0]   ram [DEPTH_WORDS];

    sel_t          wr_sel;
    logic [AW-1:0] ram_idx;
    logic          clash, wr_fire, rd_start, rd_done;
    logic          wr_data, wr_mbx, wr_addr, rd_done_data, rd_done_mbx;
    logic [1:0]    n_inc;

    // Edge detection on the strobes. A cycle with both strobes low is a
    // protocol error and fires nothing. Read completion uses the register
    // latched at read start, and only a started read can complete, so the
    // reset value of prev_r_n can never fake a completion.
    always_comb begin
        wr_sel       = sel_t'(hpi_addr);
        ram_idx      = ptr[AW:1];
        clash        = !hpi_cs_n && !hpi_r_n && !hpi_w_n;
        wr_fire      = !hpi_cs_n && !hpi_w_n && prev_w_n && hpi_r_n;
        rd_start     = !hpi_cs_n && !hpi_r_n && prev_r_n && hpi_w_n;
        rd_done      = rd_active && !prev_r_n && hpi_r_n;
        wr_data      = wr_fire && (wr_sel == SEL_DATA);
        wr_mbx       = wr_fire && (wr_sel == SEL_MBX);
        wr_addr      = wr_fire && (wr_sel == SEL_ADDR);
        rd_done_data = rd_done && (rd_sel == SEL_DATA);
        rd_done_mbx  = rd_done && (rd_sel == SEL_MBX);
        n_inc        = {1'b0, wr_data} + {1'b0, rd_done_data};
    end

    // Strobe history. Reset parks it at "low" so a strobe still held low
    // when reset releases is not seen as a fresh falling edge; it only
    // re-arms once the strobe is observed high.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_r_n <= 1'b0;
            prev_w_n <= 1'b0;
        end else begin
            prev_r_n <= hpi_r_n;
            prev_w_n <= hpi_w_n;
        end
    end

    // Read tracking and registered read data, captured at read start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_active    <= 1'b0;
            rd_sel       <= SEL_DATA;
            hpi_data_out <= '0;
        end else begin
            if (rd_start) begin
                rd_active <= 1'b1;
                rd_sel    <= wr_sel;
                case (wr_sel)
                    SEL_DATA: hpi_data_out <= ram[ram_idx];
                    SEL_MBX:  hpi_data_out <= mbx_out_val;
                    SEL_ADDR: hpi_data_out <= ptr;
                    SEL_STAT: hpi_data_out <= {14'b0, mbx_in, mbx_out};
                    default:  hpi_data_out <= '0;
                endcase
            end else if (rd_done) begin
                rd_active <= 1'b0;
            end
        end
    end

    // Address pointer: explicit load wins, otherwise advance one word per
    // DATA write and per completed DATA read (16-bit wrap is natural).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)        ptr <= RESET_ADDR;
        else if (wr_addr) ptr <= {hpi_data_in[15:1], 1'b0};
        else              ptr <= ptr + {13'b0, n_inc, 1'b0};
    end

    // Word RAM; contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (wr_data) ram[ram_idx] <= hpi_data_in;
    end

    // Mailboxes and error flag. Setting events beat clearing events.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dev_mbx_rdata <= '0;
            mbx_out_val   <= '0;
            mbx_in        <= 1'b0;
            mbx_out       <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            if (wr_mbx) begin
                dev_mbx_rdata <= hpi_data_in;
                mbx_in        <= 1'b1;
            end else if (dev_mbx_ack) begin
                mbx_in <= 1'b0;
            end
            if (dev_mbx_wr) begin
                mbx_out_val <= dev_mbx_wdata;
                mbx_out     <= 1'b1;
            end else if (rd_done_mbx) begin
                mbx_out <= 1'b0;
            end
            if (clash) protocol_err <= 1'b1;
        end
    end

    assign dev_mbx_irq = mbx_in;

endmodule

// File: tb/tb_hpi_responder.sv
// Bench for hpi_responder: directed scenarios with literal expectations,
// then randomized bus traffic, all checked every cycle against a
// transaction-level model of the register file.
module tb_hpi_responder;
    localparam int          DEPTH = 256;
    localparam logic [15:0] RADDR = 16'h0100;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  hpi_addr = 2'b00;
    logic        hpi_cs_n = 1'b1, hpi_r_n = 1'b1, hpi_w_n = 1'b1;
    logic [15:0] hpi_data_in = '0;
    logic [15:0] hpi_data_out;
    logic        dev_mbx_wr = 1'b0, dev_mbx_ack = 1'b0;
    logic [15:0] dev_mbx_wdata = '0;
    logic [15:0] dev_mbx_rdata;
    logic        dev_mbx_irq, protocol_err;

    hpi_responder #(.DEPTH_WORDS(DEPTH), .RESET_ADDR(RADDR)) dut (
        .Clk(Clk), .Reset(Reset), .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n),
        .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_data_in(hpi_data_in),
        .hpi_data_out(hpi_data_out), .dev_mbx_wr(dev_mbx_wr),
        .dev_mbx_wdata(dev_mbx_wdata), .dev_mbx_ack(dev_mbx_ack),
        .dev_mbx_rdata(dev_mbx_rdata), .dev_mbx_irq(dev_mbx_irq),
        .protocol_err(protocol_err)
    );

    always #5 Clk = ~Clk;

    // Model state, updated per transaction at the moment it is driven.
    logic [15:0] m_ptr, m_out_val, m_rdata, exp_dout;
    logic [15:0] m_ram [DEPTH];
    bit          m_known [DEPTH];
    bit          m_in, m_out, m_err, dout_known;
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] d, junk;

    function automatic int widx(input logic [15:0] p);
        return (int'(p) / 2) % DEPTH;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = RADDR; m_out_val = '0; m_rdata = '0;
        m_in = 0; m_out = 0; m_err = 0; exp_dout = '0; dout_known = 1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always begin
        @(posedge Clk); #1;
        chk("mbx_irq", 16'(dev_mbx_irq), 16'(m_in));
        chk("mbx_rdata", dev_mbx_rdata, m_rdata);
        chk("protocol_err", 16'(protocol_err), 16'(m_err));
        if (dout_known) chk("data_out", hpi_data_out, exp_dout);
    end

    task automatic hwrite(input logic [1:0] a, input logic [15:0] v, input int hold, input bit ack_too);
        @(negedge Clk);
        hpi_addr = a; hpi_data_in = v; hpi_cs_n = 0; hpi_w_n = 0;
        if (ack_too) begin dev_mbx_ack = 1; m_in = 0; end
        case (a)
            2'd0: begin m_ram[widx(m_ptr)] = v; m_known[widx(m_ptr)] = 1; m_ptr += 16'd2; end
            2'd1: begin m_rdata = v; m_in = 1; end
            2'd2: m_ptr = v & 16'hFFFE;
            default: ;
        endcase
        @(negedge Clk);
        dev_mbx_ack = 0;
        repeat (hold - 1) @(negedge Clk);
        hpi_w_n = 1; hpi_cs_n = 1;
        @(negedge Clk);
    endtask

    task automatic hread(input logic [1:0] a, input int hold, input bit wr_at_done,
                         input logic [15:0] wv, output logic [15:0] q);
        @(negedge Clk);
        hpi_addr = a; hpi_cs_n = 0; hpi_r_n = 0;
        dout_known = 1;
        case (a)
            2'd0: begin exp_dout = m_ram[widx(m_ptr)]; dout_known = m_known[widx(m_ptr)]; end
            2'd1: exp_dout = m_out_val;
            2'd2: exp_dout = m_ptr;
            default: exp_dout = {14'b0, m_in, m_out};
        endcase
        @(negedge Clk);
        q = hpi_data_out;
        repeat (hold - 1) begin hpi_addr = 2'($urandom); @(negedge Clk); end
        hpi_r_n = 1; hpi_cs_n = 1;
        if (a == 2'd0) m_ptr += 16'd2;
        if (a == 2'd1) m_out = 0;
        if (wr_at_done) begin
            dev_mbx_wr = 1; dev_mbx_wdata = wv; m_out = 1; m_out_val = wv;
        end
        @(negedge Clk);
        dev_mbx_wr = 0;
    endtask

    task automatic dev_write(input logic [15:0] v);
        @(negedge Clk);
        dev_mbx_wr = 1; dev_mbx_wdata = v; m_out = 1; m_out_val = v;
        @(negedge Clk);
        dev_mbx_wr = 0;
    endtask

    task automatic dev_ack();
        @(negedge Clk);
        dev_mbx_ack = 1; m_in = 0;
        @(negedge Clk);
        dev_mbx_ack = 0;
    endtask

    task automatic proto_err(input int hold);
        @(negedge Clk);
        hpi_addr = 2'($urandom); hpi_data_in = 16'($urandom);
        hpi_cs_n = 0; hpi_r_n = 0; hpi_w_n = 0; m_err = 1;
        repeat (hold) @(negedge Clk);
        hpi_r_n = 1; hpi_w_n = 1; hpi_cs_n = 1;
        @(negedge Clk);
    endtask

    // Strobes without chip select must do nothing at all.
    task automatic deselected(input int hold);
        @(negedge Clk);
        hpi_addr = 2'($urandom); hpi_data_in = 16'($urandom);
        hpi_cs_n = 1; hpi_r_n = 1'($urandom); hpi_w_n = 1'($urandom);
        repeat (hold) @(negedge Clk);
        hpi_r_n = 1; hpi_w_n = 1;
        @(negedge Clk);
    endtask

    task automatic reset_mid_write();
        @(negedge Clk);
        Reset = 1; hpi_addr = 2'd0; hpi_data_in = 16'hDEAD; hpi_cs_n = 0; hpi_w_n = 0;
        model_reset();
        @(negedge Clk);
        Reset = 0;
        repeat (3) @(negedge Clk);
        hpi_w_n = 1; hpi_cs_n = 1;
        @(negedge Clk);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 0;
        @(negedge Clk);

        hread(2'd3, 1, 0, '0, d); chk("rst_status", d, 16'h0000);
        hread(2'd2, 1, 0, '0, d); chk("rst_addr", d, RADDR);
        chk("rst_perr", 16'(protocol_err), 16'h0000);

        hwrite(2'd2, 16'h0010, 1, 0);
        hwrite(2'd0, 16'hBEEF, 2, 0);
        hwrite(2'd0, 16'hCAFE, 1, 0);
        hwrite(2'd2, 16'h0010, 1, 0);
        hread(2'd0, 1, 0, '0, d); chk("rd_beef", d, 16'hBEEF);
        hread(2'd0, 3, 0, '0, d); chk("rd_cafe", d, 16'hCAFE);
        hread(2'd2, 1, 0, '0, d); chk("ptr_0014", d, 16'h0014);

        hwrite(2'd2, 16'hFFFE, 1, 0);
        hwrite(2'd0, 16'h1234, 1, 0);
        hread(2'd2, 1, 0, '0, d); chk("ptr_wrap", d, 16'h0000);
        hwrite(2'd2, 16'h01FF, 1, 0);
        hread(2'd2, 1, 0, '0, d); chk("ptr_bit0", d, 16'h01FE);
        hread(2'd0, 1, 0, '0, d); chk("alias_1234", d, 16'h1234);

        hwrite(2'd1, 16'h00A5, 1, 0);
        chk("irq_set", 16'(dev_mbx_irq), 16'h0001);
        chk("mbx_rdata_a5", dev_mbx_rdata, 16'h00A5);
        hread(2'd3, 1, 0, '0, d); chk("stat_0002", d, 16'h0002);
        dev_ack();
        hread(2'd3, 1, 0, '0, d); chk("stat_ack", d, 16'h0000);

        dev_write(16'h5A5A);
        hread(2'd3, 1, 0, '0, d); chk("stat_0001", d, 16'h0001);
        hread(2'd1, 2, 0, '0, d); chk("rd_mbx", d, 16'h5A5A);
        hread(2'd3, 1, 0, '0, d); chk("stat_cleared", d, 16'h0000);

        hwrite(2'd1, 16'h1111, 1, 1);
        hread(2'd3, 1, 0, '0, d); chk("wr_vs_ack", d, 16'h0002);
        dev_ack();
        dev_write(16'h2222);
        hread(2'd1, 1, 1, 16'h3333, d); chk("rd_mbx_old", d, 16'h2222);
        hread(2'd3, 1, 0, '0, d); chk("done_vs_wr", d, 16'h0001);
        hread(2'd1, 1, 0, '0, d); chk("rd_mbx_new", d, 16'h3333);

        hwrite(2'd2, 16'h0020, 1, 0);
        proto_err(2);
        chk("perr_set", 16'(protocol_err), 16'h0001);
        hread(2'd2, 1, 0, '0, d); chk("perr_ptr", d, 16'h0020);
        hwrite(2'd0, 16'hABCD, 5, 0);
        hread(2'd2, 1, 0, '0, d); chk("long_wr_ptr", d, 16'h0022);
        hwrite(2'd2, 16'h0020, 1, 0);
        hread(2'd0, 1, 0, '0, d); chk("long_wr_data", d, 16'hABCD);
        deselected(3);
        hread(2'd2, 1, 0, '0, d); chk("desel_ptr", d, 16'h0022);
        chk("perr_sticky", 16'(protocol_err), 16'h0001);

        // Randomized traffic; the every-cycle compare does the checking.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 10))
                0, 1, 2: hwrite(2'($urandom), 16'($urandom), $urandom_range(1, 3), ($urandom_range(0, 7) == 0));
                3, 4, 5: hread(2'($urandom), $urandom_range(1, 3), ($urandom_range(0, 5) == 0), 16'($urandom), junk);
                6:       dev_write(16'($urandom));
                7:       dev_ack();
                8:       deselected($urandom_range(1, 3));
                9:       if ($urandom_range(0, 9) == 0) proto_err(1);
                default: @(negedge Clk);
            endcase
        end

        reset_mid_write();
        hread(2'd2, 1, 0, '0, d); chk("mid_rst_ptr", d, RADDR);
        chk("mid_rst_perr", 16'(protocol_err), 16'h0000);
        hread(2'd3, 1, 0, '0, d); chk("mid_rst_stat", d, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a task never returns.
    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

endmodule
